// File: rtl/mem_fill_if.sv
// mem_fill_if: control and memory-port bundle for mem_fill.
//   master: issues en/mode/seed/step/count, returns rddata; sees rdy/done/err and the memory port.
//   slave : the fill engine; drives rdy, addr/wrdata/wren, done, err/err_addr.
interface mem_fill_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              en;
  logic              rdy;
  logic [1:0]        mode;
  logic [DATA_W-1:0] seed;
  logic [DATA_W-1:0] step;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wrdata;
  logic              wren;
  logic [DATA_W-1:0] rddata;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] err_addr;
  modport master (
    output en, mode, seed, step, count, rddata,
    input  rdy, addr, wrdata, wren, done, err, err_addr
  );
  modport slave (
    input  en, mode, seed, step, count, rddata,
    output rdy, addr, wrdata, wren, done, err, err_addr
  );
endinterface

// File: rtl/mem_fill.sv
// mem_fill: fills memory words 0..count-1 (identity/constant/ramp) or verifies a ramp against read data.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_fill_if.slave -- start handshake (en/rdy), operation inputs, memory port,
//                completion pulse (done) and sticky verify mismatch flag/address (err/err_addr)
module mem_fill #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input logic     clk,
  input logic     rst_n,
  mem_fill_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  state_t            state_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] seed_q, step_q, acc_q, wrdata_q;
  logic [ADDR_W:0]   count_q, idx_q;
  logic [ADDR_W-1:0] addr_q, err_addr_q;
  logic              wren_q, done_q, err_q;
  logic [1:0]        drain_q;
  // Read-check pipeline: one slot per cycle of read latency (valid, expected word, address).
  logic [RD_LAT-1:0] pv_q;
  logic [DATA_W-1:0] pe_q [RD_LAT];
  logic [ADDR_W-1:0] pa_q [RD_LAT];
  logic [ADDR_W:0]   idx_d;
  logic [DATA_W-1:0] acc_d, wr_d, wr_start;
  logic              last;
  assign idx_d    = idx_q + (ADDR_W+1)'(1);
  assign acc_d    = acc_q + step_q;
  assign last     = idx_d >= count_q;
  assign wr_d     = mode_q == 2'd0 ? DATA_W'(idx_d) : mode_q == 2'd1 ? seed_q : acc_d;
  assign wr_start = bus.mode == 2'd0 ? '0 : bus.seed;
  assign bus.rdy      = state_q == IDLE;
  assign bus.addr     = addr_q;
  assign bus.wrdata   = wrdata_q;
  assign bus.wren     = wren_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_addr = err_addr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      seed_q     <= '0;
      step_q     <= '0;
      acc_q      <= '0;
      wrdata_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      err_addr_q <= '0;
      wren_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      drain_q    <= '0;
      pv_q       <= '0;
      for (int j = 0; j < RD_LAT; j++) begin
        pe_q[j] <= '0;
        pa_q[j] <= '0;
      end
    end else begin
      done_q  <= 1'b0;
      pv_q[0] <= state_q == READ;
      pe_q[0] <= acc_q;
      pa_q[0] <= addr_q;
      for (int j = 1; j < RD_LAT; j++) begin
        pv_q[j] <= pv_q[j-1];
        pe_q[j] <= pe_q[j-1];
        pa_q[j] <= pa_q[j-1];
      end
      if (pv_q[RD_LAT-1] && bus.rddata != pe_q[RD_LAT-1] && !err_q) begin
        err_q      <= 1'b1;
        err_addr_q <= pa_q[RD_LAT-1];
      end
      unique case (state_q)
        IDLE: if (bus.en) begin
          mode_q     <= bus.mode;
          seed_q     <= bus.seed;
          step_q     <= bus.step;
          count_q    <= bus.count;
          idx_q      <= '0;
          acc_q      <= bus.seed;
          addr_q     <= '0;
          err_q      <= 1'b0;
          err_addr_q <= '0;
          // count=0 in any mode is a single idle WRITE cycle with no write and no read.
          state_q    <= bus.count == '0 ? WRITE : bus.mode == 2'd3 ? READ : WRITE;
          wren_q     <= bus.count != '0 && bus.mode != 2'd3;
          wrdata_q   <= bus.count != '0 && bus.mode != 2'd3 ? wr_start : '0;
        end
        WRITE: if (last) begin
          state_q  <= IDLE;
          done_q   <= 1'b1;
          wren_q   <= 1'b0;
          addr_q   <= '0;
          wrdata_q <= '0;
        end else begin
          idx_q    <= idx_d;
          acc_q    <= acc_d;
          addr_q   <= ADDR_W'(idx_d);
          wrdata_q <= wr_d;
        end
        READ: if (last) begin
          state_q <= DRAIN;
          addr_q  <= '0;
          drain_q <= '0;
        end else begin
          idx_q  <= idx_d;
          acc_q  <= acc_d;
          addr_q <= ADDR_W'(idx_d);
        end
        DRAIN: if (drain_q == 2'(RD_LAT-1)) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end else begin
          drain_q <= drain_q + 2'd1;
        end
      endcase
    end
  end
endmodule

// File: doc/mem_fill.md
MEM_FILL -- requirements
Module: mem_fill

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width; depth is 2^ADDR_W.
REQ-002 Parameter DATA_W, default 8, memory word width.
REQ-003 Parameter RD_LAT, default 1, range 1..4, memory read latency in cycles from addr to valid rddata.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  start request; accepted only in a cycle where rdy=1.
REQ-007 rdy  out  1  high when idle and able to accept en.
REQ-008 mode  in  2  operation: 0 IDENTITY, 1 CONSTANT, 2 RAMP, 3 VERIFY.
REQ-009 seed  in  DATA_W  constant value (CONSTANT) or ramp start (RAMP/VERIFY).
REQ-010 step  in  DATA_W  ramp increment (RAMP/VERIFY).
REQ-011 count  in  ADDR_W+1  number of words to process, starting at address 0; legal 0..2^ADDR_W.
REQ-012 addr  out  ADDR_W  memory address.
REQ-013 wrdata  out  DATA_W  memory write data.
REQ-014 wren  out  1  memory write enable.
REQ-015 rddata  in  DATA_W  memory read data, valid RD_LAT cycles after addr.
REQ-016 done  out  1  single-cycle pulse on operation completion.
REQ-017 err  out  1  sticky VERIFY mismatch flag.
REQ-018 err_addr  out  ADDR_W  address of the first VERIFY mismatch.

Function
REQ-019 States: IDLE, WRITE, READ, DRAIN; rdy=1 only in IDLE.
REQ-020 en=1 with rdy=1 at edge k latches mode/seed/step/count, clears err and err_addr, and sets rdy=0 from cycle k+1.
REQ-021 en while rdy=0 is ignored; latched inputs do not change mid-operation.
REQ-022 Modes 0-2 enter WRITE: cycle k+1+i drives addr=i, wren=1, i=0..count-1, one word per cycle, no gaps.
REQ-023 IDENTITY wrdata = i truncated or zero-extended to DATA_W; CONSTANT wrdata = seed; RAMP wrdata = (seed + i*step) mod 2^DATA_W, computed incrementally (running sum).
REQ-024 VERIFY enters READ: cycle k+1+i drives addr=i, wren=0; then DRAIN holds RD_LAT cycles so every issued read is checked.
REQ-025 VERIFY expected value for address i is (seed + i*step) mod 2^DATA_W; rddata arriving RD_LAT cycles after addr=i is compared with it.
REQ-026 First mismatch sets err=1 and err_addr=i; later mismatches do not change err_addr; err holds until next accepted en or reset.
REQ-027 Completion: cycle after last WRITE cycle, or after last DRAIN cycle, returns to IDLE with rdy=1 and done=1 for exactly that cycle.
REQ-028 count=0: one busy cycle with wren=0 and no reads checked, then done; count=2^ADDR_W covers every address, and the address counter is ADDR_W+1 bits so it does not wrap to 0 early.
REQ-029 Busy duration (rdy=0): modes 0-2 max(count,1) cycles; VERIFY count+RD_LAT cycles (count>=1).
REQ-030 In IDLE and DRAIN: wren=0, addr=0, wrdata=0; outputs never float.
REQ-031 en accepted in the same cycle as done (rdy=1) starts the next operation with no idle gap.

Reset
REQ-032 rst_n=0 immediately forces IDLE, rdy=1, wren=0, addr=0, wrdata=0, done=0, err=0, err_addr=0.
REQ-033 Reset mid-operation aborts it: no further writes and no done pulse; en is accepted from the first edge after rst_n rises.

Verification
REQ-034 ADDR_W=8, IDENTITY, count=256 -> 256 consecutive writes addr=i/wrdata=i, wren low, rdy=1, done pulse at cycle k+257.
REQ-035 RAMP seed=8'hF0 step=3 count=10 -> wrdata F0,F3,F6,F9,FC,FF,02,05,08,0B; 8-bit wrap required.
REQ-036 VERIFY RD_LAT=2, seed=0 step=1 count=16, memory word 5 corrupted to 8'hAA and word 9 corrupted -> err=1, err_addr=5, rdy low 18 cycles.
REQ-037 count=0 any mode -> rdy low exactly 1 cycle, no wren, done pulse; en held high across done -> back-to-back restart.
REQ-038 rst_n pulsed low at write i=100 -> all outputs to reset values asynchronously, no done; new IDENTITY run restarts at addr=0.
